// File: rtl/alu_exec_unit.sv
`timescale 1ns/1ps
// alu_exec_unit: execution-stage ALU. Logic and arithmetic ops finish in one
// cycle. Shifts are iterative and move one bit per cycle, with a
// start/busy/done handshake. The result and flags are registered and hold
// their value between completions.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_NEG = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_sign;

    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_shift_next;

    assign w_shamt    = op_b[SHW-1:0];
    assign w_is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRA) || (alu_op == OP_SRL);

    // Both adders are WIDTH+1 wide, so the top bit is the ADD carry or the
    // SUB borrow. A borrow occurs exactly when a < b as unsigned values.
    assign w_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign w_diff = {1'b0, op_a} - {1'b0, op_b};
    assign w_slt  = $signed(op_a) < $signed(op_b);

    // Single-cycle result. A shift only takes this path when its shift
    // amount is 0, and in that case the result is op_a unchanged.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave a latch behind.
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_result = w_diff[WIDTH-1:0];
                w_alu_carry  = w_diff[WIDTH];
            end
            OP_AND:                 w_alu_result = op_a & op_b;
            OP_OR:                  w_alu_result = op_a | op_b;
            OP_XOR:                 w_alu_result = op_a ^ op_b;
            OP_NOT:                 w_alu_result = ~op_a;
            OP_SLL, OP_SRA, OP_SRL: w_alu_result = op_a;
            OP_NEG:                 w_alu_result = '0 - op_b;
            OP_SLT:                 w_alu_result = WIDTH'(w_slt);
            default:                w_alu_result = '0;
        endcase
    end

    // One-bit step of the iterative shifter, selected by the latched opcode.
    always_comb begin
        w_shift_next = {1'b0, r_shreg[WIDTH-1:1]};
        case (r_op)
            OP_SLL:  w_shift_next = {r_shreg[WIDTH-2:0], 1'b0};
            OP_SRA:  w_shift_next = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
            default: w_shift_next = {1'b0, r_shreg[WIDTH-1:1]};
        endcase
    end

    // Control FSM and datapath registers. The result and flags are written
    // only on a completion and keep their value on every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_shreg <= op_a;
                            r_cnt   <= w_shamt;
                            r_op    <= alu_op;
                            r_state <= S_SHIFT;
                        end else begin
                            r_result <= w_alu_result;
                            r_zero   <= (w_alu_result == '0);
                            r_carry  <= w_alu_carry;
                            r_sign   <= w_alu_result[WIDTH-1];
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_shreg <= w_shift_next;
                    r_cnt   <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                        r_carry  <= 1'b0;
                        r_sign   <= w_shift_next[WIDTH-1];
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == S_SHIFT);
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;
    assign carry  = r_carry;
    assign sign   = r_sign;

endmodule
